// File: rtl/btn_pulse_gen.sv
// ----------------------------------------------------------------------------
// btn_pulse_gen
//   Turns a raw board push-button into clean control strobes for the LED-select
//   FSM. The button is passed through a 2-flop synchroniser and then a debounce
//   FSM. A new level is accepted only after it has been stable for
//   DEBOUNCE_CYCLES consecutive cycles.
//
//   Optional feature macro: HOLD_REPEAT_EN
//     When it is defined, a held button generates auto-repeat press pulses:
//     the first one after REPEAT_DELAY cycles, then one every REPEAT_PERIOD
//     cycles.
//
// Ports
//   clk            in   system clock; all logic runs on the rising edge
//   rst            in   asynchronous, active-high reset
//   btn_in         in   raw asynchronous button input (active-high, bouncy)
//   btn_level      out  debounced button level (registered)
//   press_pulse    out  one-cycle strobe on an accepted press (and on each auto-repeat)
//   release_pulse  out  one-cycle strobe on an accepted release
// ----------------------------------------------------------------------------
module btn_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 20_000_000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("btn_pulse_gen: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1, s2;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             level_n, press_n, release_n;

    // Synchroniser: s2 is the only view of the button that the FSM uses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
        end
    end

`ifdef HOLD_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    // rep_phase marks that the initial delay has already expired, so rcnt now
    // measures the repeat period instead of the initial delay.
    logic [CNT_W-1:0] rcnt, rcnt_n;
    logic             rep_phase, rep_phase_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt      <= '0;
            rep_phase <= 1'b0;
        end else begin
            rcnt      <= rcnt_n;
            rep_phase <= rep_phase_n;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            btn_level     <= level_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        level_n   = btn_level;
        press_n   = 1'b0;
        release_n = 1'b0;
`ifdef HOLD_REPEAT_EN
        rcnt_n      = rcnt;
        rep_phase_n = rep_phase;
`endif
        unique case (state)
            IDLE: begin
                if (s2) begin
                    state_n = PRESS_WAIT;
                    cnt_n   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_n = IDLE;
                end else if (cnt == DB_LAST) begin
                    state_n = PRESSED;
                    press_n = 1'b1;
                    level_n = 1'b1;
`ifdef HOLD_REPEAT_EN
                    rcnt_n      = '0;
                    rep_phase_n = 1'b0;
`endif
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s2) begin
                    state_n = RELEASE_WAIT;
                    cnt_n   = '0;
                end
`ifdef HOLD_REPEAT_EN
                // rcnt advances only while the button is held steadily; a
                // release bounce freezes it until the FSM returns here.
                else if (!rep_phase && rcnt == RD_LAST) begin
                    press_n     = 1'b1;
                    rep_phase_n = 1'b1;
                    rcnt_n      = '0;
                end else if (rep_phase && rcnt == RP_LAST) begin
                    press_n = 1'b1;
                    rcnt_n  = '0;
                end else begin
                    rcnt_n = rcnt + CNT_W'(1);
                end
`endif
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    state_n = PRESSED;
                end else if (cnt == DB_LAST) begin
                    state_n   = IDLE;
                    release_n = 1'b1;
                    level_n   = 1'b0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_btn_pulse_gen.sv
module tb_btn_pulse_gen;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic btn_level, press_pulse, release_pulse;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: the output level flips once the synchronised input has
    // disagreed with it for DB+1 consecutive samples (one IDLE/PRESSED sample
    // plus DB debounce samples).
    logic m_s1, m_s2, m_lvl, m_press, m_rel;
    int   m_run, m_hold;

    btn_pulse_gen #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .CNT_W          (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_press = 0; m_rel = 0;
        m_run = 0; m_hold = 0;
    endtask

    task automatic model_step();
        bit hold_ok;
        m_press = 0;
        m_rel   = 0;
        hold_ok = m_lvl && m_s2 && (m_run == 0);
        if (m_s2 != m_lvl) begin
            m_run++;
            if (m_run == DB + 1) begin
                m_lvl = ~m_lvl;
                m_run = 0;
                if (m_lvl) begin
                    m_press = 1;
                    m_hold  = 0;
                end else begin
                    m_rel = 1;
                end
            end
        end else begin
            m_run = 0;
        end
`ifdef HOLD_REPEAT_EN
        if (hold_ok) begin
            m_hold++;
            if (m_hold >= RD && (m_hold - RD) % RP == 0) m_press = 1;
        end
`else
        if (hold_ok) m_hold++;
`endif
        m_s2 = m_s1;
        m_s1 = btn_in;
    endtask

    task automatic check_outputs();
        check_eq("level",   int'(btn_level),     int'(m_lvl));
        check_eq("press",   int'(press_pulse),   int'(m_press));
        check_eq("release", int'(release_pulse), int'(m_rel));
        check_eq("excl",    int'(press_pulse & release_pulse), 0);
    endtask

    // One clock: drive at negedge, model at posedge, check at next negedge.
    task automatic tick(input logic b);
        btn_in = b;
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) tick(b);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        model_reset();
        #1;
        check_eq("rst_level",   int'(btn_level),     0);
        check_eq("rst_press",   int'(press_pulse),   0);
        check_eq("rst_release", int'(release_pulse), 0);
        hold(btn_in, n);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        // Button held through reset: fresh press after full latency.
        btn_in = 1'b1;
        do_reset(3);
        hold(1'b1, 10);
        // Clean release and press held 20 cycles.
        hold(1'b0, 10);
        hold(1'b1, 20);
        hold(1'b0, 10);
        // Press bounce then stable.
        hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 2);
        hold(1'b1, 12);
        // Release glitch while held.
        hold(1'b0, 2);
        hold(1'b1, 10);
        hold(1'b0, 10);
        // Reset two cycles into PRESS_WAIT.
        hold(1'b1, 4);
        do_reset(2);
        hold(1'b1, 10);
        // Long hold exercises auto-repeat when enabled.
        hold(1'b0, 10);
        hold(1'b1, 40);
        hold(1'b0, 10);
        // Randomised runs with occasional long holds and resets.
        for (int r = 0; r < 600; r++) begin
            int len;
            if ($urandom_range(0, 99) < 2) begin
                do_reset($urandom_range(1, 3));
            end
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 40)
                                              : $urandom_range(1, 8);
            hold(logic'($urandom_range(0, 1)), len);
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
